// File: rtl/apollo_pkg.sv
// Shared definitions for the uplink framing path: header byte and framer state set.
package apollo_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        LEN,
        PAY,
        SUM,
        GAP
    } framer_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with first-word-fall-through output; a write on a full FIFO succeeds
// only when a read retires the head entry in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = wr_en && (!full || rd_en);
    assign w_pop   = rd_en && !empty;
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uplink_framer.sv
// Packs buffered receiver bytes into AA/LEN/payload/CHK frames and paces them
// one byte per BYTE_GAP+1 cycles into the UART transmitter.
module uplink_framer
    import apollo_pkg::*;
#(
    parameter int PAYLOAD_LEN = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int BYTE_GAP    = 52100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       den,
    input  logic       flush,
    output logic [7:0] tx_in,
    output logic       tx_write,
    output logic       busy,
    output logic       overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam logic [CW-1:0] P_CNT    = CW'(PAYLOAD_LEN);
    localparam logic [GW-1:0] GAP_LOAD = GW'(BYTE_GAP - 1);

    framer_state_t r_state;
    framer_state_t r_prev;
    logic [7:0]    r_tx_in;
    logic          r_tx_write;
    logic          r_busy;
    logic          r_overflow;
    logic          r_flush_pend;
    logic [7:0]    r_len;
    logic [7:0]    r_sent;
    logic [7:0]    r_chk;
    logic [GW-1:0] r_gap;

    logic [7:0]    w_fifo_data;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_pop;
    logic          w_start;
    logic [7:0]    w_len;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (den),
        .wr_data (din),
        .rd_en   (w_pop),
        .rd_data (w_fifo_data),
        .count   (w_fifo_count),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // The payload byte is loaded into tx_in on entry to PAY and retired during PAY.
    assign w_pop   = (r_state == PAY);
    assign w_start = (w_fifo_count >= P_CNT) || (r_flush_pend && !w_fifo_empty);
    assign w_len   = (w_fifo_count >= P_CNT) ? 8'(PAYLOAD_LEN) : 8'(w_fifo_count);

    assign tx_in    = r_tx_in;
    assign tx_write = r_tx_write;
    assign busy     = r_busy;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (den && w_fifo_full && !w_pop) r_overflow <= 1'b1;
            if (flush)
                r_flush_pend <= 1'b1;
            else if (r_state == IDLE && (w_start || w_fifo_empty))
                r_flush_pend <= 1'b0;
        end
    end

    // Each byte state is entered with tx_write already set, so the state's single
    // cycle is the strobe cycle; GAP then decides which byte to issue next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prev     <= IDLE;
            r_tx_in    <= '0;
            r_tx_write <= 1'b0;
            r_busy     <= 1'b0;
            r_len      <= '0;
            r_sent     <= '0;
            r_chk      <= '0;
            r_gap      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= HEAD;
                        r_len      <= w_len;
                        r_sent     <= '0;
                        r_tx_in    <= FRAME_HEADER;
                        r_tx_write <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                HEAD, LEN, PAY, SUM: begin
                    r_tx_write <= 1'b0;
                    r_gap      <= GAP_LOAD;
                    r_prev     <= r_state;
                    r_state    <= GAP;
                    if (r_state == HEAD) r_chk <= '0;
                end
                GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end else begin
                        case (r_prev)
                            HEAD: begin
                                r_state    <= LEN;
                                r_tx_in    <= r_len;
                                r_chk      <= r_chk + r_len;
                                r_tx_write <= 1'b1;
                            end
                            LEN, PAY: begin
                                r_tx_write <= 1'b1;
                                if (r_sent < r_len) begin
                                    r_state <= PAY;
                                    r_tx_in <= w_fifo_data;
                                    r_chk   <= r_chk + w_fifo_data;
                                    r_sent  <= r_sent + 1'b1;
                                end else begin
                                    r_state <= SUM;
                                    r_tx_in <= r_chk;
                                end
                            end
                            default: begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uplink_framer.sv
// Bench for uplink_framer: directed scenarios plus random traffic against a
// frame-timeline reference model.
module tb_uplink_framer;

    localparam int P = 16;
    localparam int D = 32;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       den = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] tx_in;
    logic       tx_write;
    logic       busy;
    logic       overflow;

    uplink_framer #(
        .PAYLOAD_LEN (P),
        .FIFO_DEPTH  (D),
        .BYTE_GAP    (G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .den      (den),
        .flush    (flush),
        .tx_in    (tx_in),
        .tx_write (tx_write),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, frame timeline position, sticky flags.
    logic [7:0] q[$];
    logic [7:0] m_frame[$];
    logic [7:0] cap[$];
    bit         m_busy;
    int         m_pos;
    int         m_len;
    bit         m_fp;
    bit         m_ov;
    logic [7:0] m_txin;
    int         m_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0;
        m_pos  = 0;
        m_fp   = 0;
        m_ov   = 0;
        m_txin = 8'h00;
    endtask

    task automatic model_step(input bit e, input logic [7:0] d, input bit fl, input bit rn);
        bit pop_now;
        bit push_ok;
        int sum;
        if (!rn) begin
            model_reset();
            return;
        end
        pop_now = m_busy && (m_pos % (G+1) == 0) && (m_pos / (G+1) >= 2)
                  && (m_pos / (G+1) < 2 + m_len);
        push_ok = e && (q.size() < D || pop_now);
        if (e && !push_ok) m_ov = 1;
        if (!m_busy) begin
            if (q.size() >= P || (m_fp && q.size() > 0)) begin
                m_len = (q.size() >= P) ? P : q.size();
                m_frame.delete();
                m_frame.push_back(8'hAA);
                m_frame.push_back(8'(m_len));
                sum = m_len;
                for (int i = 0; i < m_len; i++) begin
                    m_frame.push_back(q[i]);
                    sum += q[i];
                end
                m_frame.push_back(8'(sum));
                m_busy = 1;
                m_pos  = 0;
                m_fp   = 0;
            end else begin
                m_fp = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == (m_len + 3) * (G + 1)) m_busy = 0;
        end
        if (pop_now) void'(q.pop_front());
        if (push_ok) begin
            q.push_back(d);
            m_acc++;
        end
        if (fl) m_fp = 1;
    endtask

    task automatic cycle(input bit e, input logic [7:0] d, input bit fl, input bit rn);
        bit exp_tw;
        @(negedge clk);
        exp_tw = m_busy && (m_pos % (G+1) == 0);
        if (exp_tw) m_txin = m_frame[m_pos / (G+1)];
        check("tx_write", tx_write, exp_tw);
        check("busy", busy, m_busy);
        check("overflow", overflow, m_ov);
        check("tx_in", tx_in, m_txin);
        if (tx_write) cap.push_back(tx_in);
        den = e; din = d; flush = fl; rst_n = rn;
        @(posedge clk);
        model_step(e, d, fl, rn);
    endtask

    task automatic settle();
        int n = 0;
        while ((m_busy || q.size() >= P || m_fp) && n < 3000) begin
            cycle(0, 8'h00, 0, 1);
            n++;
        end
        check("settle_timeout", n < 3000, 1);
    endtask

    task automatic wait_pay();
        int n = 0;
        while (!(m_busy && m_pos >= 3 * (G+1)) && n < 500) begin
            cycle(0, 8'h00, 0, 1);
            n++;
        end
        check("pay_timeout", n < 500, 1);
    endtask

    initial begin
        logic [7:0] exp_b[$];
        int idx;
        int paid;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        cycle(0, 8'h00, 0, 1);

        // Full 16-byte frame of 01..10.
        cap.delete();
        for (int i = 1; i <= 16; i++) cycle(1, 8'(i), 0, 1);
        settle();
        exp_b = {8'hAA, 8'h10};
        for (int i = 1; i <= 16; i++) exp_b.push_back(8'(i));
        exp_b.push_back(8'h98);
        check("t1_count", cap.size(), 19);
        for (int i = 0; i < 19; i++) check("t1_byte", cap[i], exp_b[i]);

        // Short flushed frame, then flush on an empty FIFO.
        cap.delete();
        for (int i = 0; i < 3; i++) cycle(1, 8'hFF, 0, 1);
        cycle(0, 8'h00, 1, 1);
        settle();
        exp_b = {8'hAA, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        check("t2_count", cap.size(), 6);
        for (int i = 0; i < 6; i++) check("t2_byte", cap[i], exp_b[i]);
        cap.delete();
        cycle(0, 8'h00, 1, 1);
        repeat (30) cycle(0, 8'h00, 0, 1);
        check("t2_empty_flush", cap.size(), 0);

        // Overflow: 40 back-to-back pushes.
        cap.delete();
        m_acc = 0;
        for (int i = 0; i < 40; i++) cycle(1, 8'($urandom), 0, 1);
        check("t3_ovf_flag", overflow, 1);
        settle();
        cycle(0, 8'h00, 1, 1);
        settle();
        check("t3_ovf_sticky", overflow, 1);
        idx = 0;
        paid = 0;
        while (idx + 1 < cap.size()) begin
            paid += cap[idx+1];
            idx  += cap[idx+1] + 3;
        end
        check("t3_survivors", paid, m_acc);

        // Bytes arriving mid-frame go into the next frame.
        cap.delete();
        for (int i = 0; i < 16; i++) cycle(1, 8'($urandom), 0, 1);
        wait_pay();
        for (int i = 0; i < 10; i++) cycle(1, 8'(8'hC0 + i), 0, 1);
        settle();
        cycle(0, 8'h00, 1, 1);
        settle();
        check("t4_count", cap.size(), 19 + 13);
        check("t4_len1", cap[1], 8'h10);
        check("t4_len2", cap[20], 8'h0A);
        for (int i = 0; i < 10; i++) check("t4_pay2", cap[21+i], 8'(8'hC0 + i));

        // Reset during PAY abandons the frame and clears overflow.
        cap.delete();
        for (int i = 0; i < 16; i++) cycle(1, 8'($urandom), 0, 1);
        wait_pay();
        cycle(0, 8'h00, 0, 0);
        #1;
        check("t5_txw", tx_write, 0);
        check("t5_busy", busy, 0);
        check("t5_txin", tx_in, 8'h00);
        check("t5_ovf", overflow, 0);
        cap.delete();
        repeat (200) cycle(0, 8'h00, 0, 1);
        check("t5_no_resume", cap.size(), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 99) == 0, 1);
        settle();
        cycle(0, 8'h00, 1, 1);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
